// File: rtl/robot_pkg.sv
// Shared definitions for the wheel-speed path: FSM states, default sizing
// and a signed saturation helper.
package robot_pkg;

  typedef enum logic [1:0] {IDLE, PRIME, FILL, RUN} spd_state_t;

  localparam int ENC_CNT_W      = 20;
  localparam int SPD_WIN_CYCLES = 500000;
  localparam int SPEED_W        = 16;

  // Clamp a signed value into the range of a width-bit signed number (width 2..31).
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] val,
                                                    input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (val > hi) return hi;
    else if (val < lo) return lo;
    else return val;
  endfunction

endpackage

// File: rtl/speed_avg_ring.sv
// Moving average over the last 2^DEPTH_LOG2 samples. avg/full show the state
// that results from the push happening this cycle, so the caller can register them.
module speed_avg_ring #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                     clk_50M,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] avg,
  output logic                     full
);
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int SUM_W  = DATA_W + DEPTH_LOG2;
  localparam int PTR_W  = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
  localparam int FILL_W = DEPTH_LOG2 + 1;

  logic signed [DATA_W-1:0] buf_q [DEPTH];
  logic signed [DATA_W-1:0] buf_d [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0]        fill_q, fill_d;
  logic signed [SUM_W-1:0]  sum_q, sum_d;

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    sum_d    = sum_q;
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) buf_d[i] = '0;
      wr_ptr_d = '0;
      fill_d   = '0;
      sum_d    = '0;
    end else if (push) begin
      buf_d[wr_ptr_q] = din;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (fill_q != FILL_W'(DEPTH)) fill_d = fill_q + 1'b1;
      sum_d = sum_q + SUM_W'(din) - SUM_W'(buf_q[wr_ptr_q]);
    end
  end

  assign avg  = DATA_W'(sum_d >>> DEPTH_LOG2);
  assign full = (fill_d == FILL_W'(DEPTH));

  // NOTE: the buffer is cleared on reset because the running sum always subtracts
  // the slot being overwritten, even while the buffer is still filling.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      sum_q    <= '0;
    end else begin
      buf_q    <= buf_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      sum_q    <= sum_d;
    end
  end

endmodule

// File: rtl/encoder_speed_meter.sv
// Encoder wheel-speed meter: windowed signed delta with wrap, moving average,
// stall and sticky saturation flags. Define SPEED_DIR_INVERT_EN to negate deltas.
module encoder_speed_meter #(
  parameter int CNT_W      = robot_pkg::ENC_CNT_W,
  parameter int WIN_CYCLES = robot_pkg::SPD_WIN_CYCLES,
  parameter int SPEED_W    = robot_pkg::SPEED_W,
  parameter int AVG_LOG2   = 2
) (
  input  logic                      clk_50M,
  input  logic                      reset,
  input  logic [CNT_W-1:0]          counter,
  input  logic                      enable,
  output logic signed [SPEED_W-1:0] speed,
  output logic                      speed_valid,
  output logic                      stalled,
  output logic                      sat
);
  import robot_pkg::*;

  localparam int TMR_W = $clog2(WIN_CYCLES);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int ZC_W  = AVG_LOG2 + 1;

  spd_state_t                state_q, state_d;
  logic [TMR_W-1:0]          timer_q, timer_d;
  logic [CNT_W-1:0]          prev_q, prev_d;
  logic [ZC_W-1:0]           zero_cnt_q, zero_cnt_d;
  logic signed [SPEED_W-1:0] speed_q, speed_d;
  logic                      speed_valid_q, speed_valid_d;
  logic                      stalled_q, stalled_d;
  logic                      sat_q, sat_d;

  logic                      tick, measuring, push;
  logic [CNT_W-1:0]          diff;
  logic signed [31:0]        delta_ext, delta_clip;
  logic signed [SPEED_W-1:0] delta_buf, ring_avg;
  logic                      delta_sat, ring_full;

  // Modular difference reinterpreted as signed absorbs counter wrap in either direction.
  always_comb begin
    diff       = counter - prev_q;
    delta_ext  = 32'(signed'(diff));
    delta_clip = sat_signed(delta_ext, SPEED_W);
    delta_sat  = (delta_clip != delta_ext);
`ifdef SPEED_DIR_INVERT_EN
    delta_buf  = SPEED_W'(sat_signed(-delta_clip, SPEED_W));
    delta_sat  = delta_sat | (sat_signed(-delta_clip, SPEED_W) != -delta_clip);
`else
    delta_buf  = SPEED_W'(delta_clip);
`endif
  end

  assign tick      = (state_q != IDLE) && (timer_q == TMR_W'(WIN_CYCLES - 1));
  assign measuring = (state_q == FILL) || (state_q == RUN);
  assign push      = enable && tick && measuring;

  speed_avg_ring #(
    .DATA_W     (SPEED_W),
    .DEPTH_LOG2 (AVG_LOG2)
  ) u_ring (
    .clk_50M (clk_50M),
    .reset   (reset),
    .clear   (!enable),
    .push    (push),
    .din     (delta_buf),
    .avg     (ring_avg),
    .full    (ring_full)
  );

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    prev_d        = prev_q;
    zero_cnt_d    = zero_cnt_q;
    speed_d       = speed_q;
    speed_valid_d = 1'b0;
    stalled_d     = stalled_q;
    sat_d         = sat_q;
    if (!enable) begin
      state_d    = IDLE;
      timer_d    = '0;
      zero_cnt_d = '0;
      speed_d    = '0;
      stalled_d  = 1'b0;
    end else if (state_q == IDLE) begin
      state_d = PRIME;
      timer_d = '0;
    end else begin
      timer_d = tick ? '0 : timer_q + 1'b1;
      if (tick) begin
        prev_d = counter;
        if (state_q == PRIME) begin
          state_d = FILL;
        end else begin
          sat_d = sat_q | delta_sat;
          if (diff != '0) zero_cnt_d = '0;
          else if (zero_cnt_q != ZC_W'(DEPTH)) zero_cnt_d = zero_cnt_q + 1'b1;
          stalled_d = (zero_cnt_d == ZC_W'(DEPTH));
          if (ring_full) begin
            state_d       = RUN;
            speed_d       = ring_avg;
            speed_valid_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      prev_q        <= '0;
      zero_cnt_q    <= '0;
      speed_q       <= '0;
      speed_valid_q <= 1'b0;
      stalled_q     <= 1'b0;
      sat_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      prev_q        <= prev_d;
      zero_cnt_q    <= zero_cnt_d;
      speed_q       <= speed_d;
      speed_valid_q <= speed_valid_d;
      stalled_q     <= stalled_d;
      sat_q         <= sat_d;
    end
  end

  assign speed       = speed_q;
  assign speed_valid = speed_valid_q;
  assign stalled     = stalled_q;
  assign sat         = sat_q;

endmodule

// File: tb/tb_encoder_speed_meter.sv
// Directed bench for encoder_speed_meter: three instances cover steady motion,
// stall, disable/re-enable and reset (avg depth 4), wrap (depth 1), saturation (8-bit speed).
`timescale 1ns/1ps
module tb_encoder_speed_meter;
  localparam int CNT_W = 20;
  localparam int WIN   = 100;
`ifdef SPEED_DIR_INVERT_EN
  localparam int DIR = -1;
`else
  localparam int DIR = 1;
`endif

  logic clk_50M = 1'b0;
  logic reset;
  logic [CNT_W-1:0] counter_a = '0;
  logic [CNT_W-1:0] counter_b, counter_c;
  logic enable_a, enable_b, enable_c, motion_a;
  logic signed [15:0] speed_a, speed_b;
  logic signed [7:0]  speed_c;
  logic valid_a, valid_b, valid_c;
  logic stalled_a, stalled_b, stalled_c;
  logic sat_a, sat_b, sat_c;
  int n_checks = 0;
  int n_fail   = 0;
  int phase_a  = 0;

  always #10 clk_50M = ~clk_50M;

  encoder_speed_meter #(.CNT_W(CNT_W), .WIN_CYCLES(WIN), .SPEED_W(16), .AVG_LOG2(2)) u_dut_a (
    .clk_50M(clk_50M), .reset(reset), .counter(counter_a), .enable(enable_a),
    .speed(speed_a), .speed_valid(valid_a), .stalled(stalled_a), .sat(sat_a));
  encoder_speed_meter #(.CNT_W(CNT_W), .WIN_CYCLES(WIN), .SPEED_W(16), .AVG_LOG2(0)) u_dut_b (
    .clk_50M(clk_50M), .reset(reset), .counter(counter_b), .enable(enable_b),
    .speed(speed_b), .speed_valid(valid_b), .stalled(stalled_b), .sat(sat_b));
  encoder_speed_meter #(.CNT_W(CNT_W), .WIN_CYCLES(WIN), .SPEED_W(8), .AVG_LOG2(0)) u_dut_c (
    .clk_50M(clk_50M), .reset(reset), .counter(counter_c), .enable(enable_c),
    .speed(speed_c), .speed_valid(valid_c), .stalled(stalled_c), .sat(sat_c));

  // Encoder A moves +3 every 10 cycles of motion, so any 100-cycle window sees +30.
  always @(negedge clk_50M) begin
    #1;
    if (motion_a) begin
      phase_a++;
      if (phase_a == 10) begin
        phase_a   = 0;
        counter_a = counter_a + 3;
      end
    end
  end

  task automatic check(input string tag, input logic signed [31:0] actual,
                       input logic signed [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int clip(input int v, input int w);
    int hi = (1 << (w - 1)) - 1;
    int lo = -(1 << (w - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  function automatic int dir_delta(input int v, input int w);
    return (DIR < 0) ? clip(-clip(v, w), w) : clip(v, w);
  endfunction

  function automatic logic get_valid(input int which);
    case (which)
      0:       return valid_a;
      1:       return valid_b;
      default: return valid_c;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  // Counts negedges until the selected valid is seen; the count itself is checked.
  task automatic wait_valid(input int which, input string tag, input int exp_cycles);
    int cycles = 0;
    do begin
      @(negedge clk_50M);
      cycles++;
    end while (!get_valid(which) && cycles < 2000);
    check(tag, cycles, exp_cycles);
  endtask

  initial begin
    reset     = 1'b1;
    enable_a  = 1'b0;
    enable_b  = 1'b0;
    enable_c  = 1'b0;
    motion_a  = 1'b0;
    counter_b = '0;
    counter_c = '0;
    step(3);
    reset = 1'b0;
    check("rst_speed", speed_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_stalled", stalled_a, 0);
    check("rst_sat", sat_a, 0);

    // Wrap in both directions, depth 1 so speed equals the delta.
    counter_b = 20'hFFFFE;
    enable_b  = 1'b1;
    step(150);
    counter_b = 20'h00003;
    wait_valid(1, "wrap_latency", 51);
    check("wrap_up", speed_b, dir_delta(5, 16));
    counter_b = 20'h00002;
    wait_valid(1, "wrap_period", 100);
    check("small_down", speed_b, dir_delta(-1, 16));
    counter_b = 20'hFFFFF;
    wait_valid(1, "wrap_period2", 100);
    check("wrap_down", speed_b, dir_delta(-3, 16));
    check("wrap_no_sat", sat_b, 0);
    check("wrap_no_stall", stalled_b, 0);

    // Disable on the tick cycle of the first push: no valid may follow.
    enable_b = 1'b0;
    step(2);
    enable_b = 1'b1;
    step(200);
    enable_b = 1'b0;
    step(1);
    check("tick_disable_valid", valid_b, 0);
    check("tick_disable_speed", speed_b, 0);

    // Saturation at 8-bit speed; sat is sticky through disable.
    enable_c = 1'b1;
    step(150);
    counter_c = 20'd300;
    wait_valid(2, "sat_latency", 51);
    check("sat_pos", speed_c, dir_delta(300, 8));
    check("sat_flag", sat_c, 1);
    counter_c = 20'd100;
    wait_valid(2, "sat_period", 100);
    check("sat_neg", speed_c, dir_delta(-200, 8));
    counter_c = 20'd105;
    wait_valid(2, "sat_period2", 100);
    check("sat_small", speed_c, dir_delta(5, 8));
    check("sat_sticky", sat_c, 1);
    enable_c = 1'b0;
    step(2);
    check("sat_after_disable", sat_c, 1);
    check("speed_after_disable_c", speed_c, 0);

    // Steady motion: PRIME + 4 FILL windows, then one valid every window.
    enable_a = 1'b1;
    motion_a = 1'b1;
    wait_valid(0, "steady_first", 501);
    check("steady_speed", speed_a, 30 * DIR);
    step(1);
    check("valid_pulse", valid_a, 0);
    wait_valid(0, "steady_period", 99);
    check("steady_speed2", speed_a, 30 * DIR);
    check("steady_no_stall", stalled_a, 0);

    // Stall: four zero-delta windows drain the average.
    motion_a = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      wait_valid(0, "stall_period", 100);
      check("stall_speed", speed_a, (DIR * 30 * (4 - k)) >>> 2);
      check("stall_flag", stalled_a, (k == 4) ? 1 : 0);
    end
    motion_a = 1'b1;
    wait_valid(0, "resume_period", 100);
    check("resume_speed", speed_a, (DIR * 30) >>> 2);
    check("resume_stall", stalled_a, 0);

    // Disable mid-RUN, then re-enable restarts from PRIME.
    step(30);
    enable_a = 1'b0;
    step(1);
    check("dis_speed", speed_a, 0);
    check("dis_stalled", stalled_a, 0);
    check("dis_valid", valid_a, 0);
    step(5);
    enable_a = 1'b1;
    wait_valid(0, "reenable_first", 501);
    check("reenable_speed", speed_a, 30 * DIR);
    check("a_no_sat", sat_a, 0);

    // Reset mid-window clears everything, including sticky sat elsewhere.
    step(50);
    reset = 1'b1;
    step(1);
    check("midrst_speed", speed_a, 0);
    check("midrst_valid", valid_a, 0);
    check("midrst_stalled", stalled_a, 0);
    check("midrst_sat_c", sat_c, 0);
    reset    = 1'b0;
    enable_a = 1'b0;
    motion_a = 1'b0;
    step(2);
    check("idle_stalled_c", stalled_c, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
